bram_transpose_ctrl: RTL and testbench
======================================

# bram_transpose_ctrl

Initiator-side controller that drives both ports of the dual-port M20K BRAM core to perform streaming NxN tile transposition. It accepts a row-major element stream, writes it through port A into one of two ping-pong banks, then reads the completed bank column-major through port B into a valid/ready output stream. It sits between the upstream producer and downstream consumer, and it is the only master of the BRAM instance.

## Interface
- DATA_WIDTH, 8: element width; must equal the BRAM logical width.
- DEPTH, 2048: BRAM logical depth.
- TILE_DIM, 16: N; power of two, N >= 2.
- PHYS_COLS, 160: BRAM physical columns; WPR = PHYS_COLS/DATA_WIDTH words per physical row.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input element valid.
- s_ready  out  1  controller can accept an input element.
- s_data  in  DATA_WIDTH  input element, row-major order.
- m_valid  out  1  output element valid.
- m_ready  in  1  consumer accepts the output element.
- m_data  out  DATA_WIDTH  output element, column-major order.
- m_last  out  1  last element of the tile.
- mem_addr_a, mem_addr_b  out  $clog2(DEPTH)  BRAM addresses.
- mem_din_a  out  DATA_WIDTH  BRAM write data; mem_din_b is tied to 0.
- mem_wen_a  out  1  port A write enable; mem_ren_a is tied to 0.
- mem_ren_b  out  1  port B read enable; mem_wen_b is tied to 0.
- mem_dout_b  in  DATA_WIDTH  BRAM port B registered read data.

## Operation
- Bank base addresses: BASE0 = 0, BASE1 = ceil(N*N/WPR)*WPR.
  - This alignment puts the two banks in disjoint physical rows, so port A and port B never collide.
  - Elaboration error if BASE1 + N*N > DEPTH.
- Each bank has a state: EMPTY, FILLING, FULL or DRAINING.
- Writer (port A):
  - s_ready = 1 when bank[wr_bank] is EMPTY or FILLING.
  - On s_valid & s_ready:
    - mem_wen_a = 1, mem_addr_a = BASE[wr_bank] + wr_cnt, mem_din_a = s_data.
    - wr_cnt increments.
    - On the first element, the bank moves EMPTY to FILLING.
    - When wr_cnt = N*N-1: bank moves to FULL, wr_cnt clears to 0, wr_bank toggles.
- Reader (port B):
  - When bank[rd_bank] is FULL, it moves to DRAINING.
  - Reads are issued as mem_ren_b = 1, mem_addr_b = BASE[rd_bank] + r*N + c.
    - r is the inner counter and c the outer counter, so the read order is column-major.
  - A read is issued only when fifo_occupancy + pending < 3. pending is 1 if a read was issued in the previous cycle.
  - On issuing the read at r = c = N-1: the bank moves to EMPTY, the counters clear, and rd_bank toggles.
- Output FIFO:
  - Three entries, each {data, last}.
  - An entry is captured from mem_dout_b in the cycle after its read issue.
  - m_valid = FIFO not empty. An element pops on m_valid & m_ready.
  - m_last is 1 only for the element at r = c = N-1.
- Simultaneous events:
  - A writer FULL transition and a reader EMPTY transition in the same cycle both apply.
  - FIFO push and pop in the same cycle keep occupancy unchanged.
- A bank is never written while it is FULL or DRAINING, and never read while it is EMPTY or FILLING.

## Timing
- Reset state:
  - Both banks EMPTY; wr_bank = rd_bank = 0; all counters 0; FIFO empty; pending = 0.
  - s_ready = 1, m_valid = 0, m_data = 0, m_last = 0.
  - mem_wen_a = mem_ren_b = 0, all mem addresses 0, mem_din_a = 0.
- Memory outputs are combinational from registered state. The BRAM samples them at the next clk edge.
- Latency:
  - The last input is accepted in cycle L.
  - The first read is issued in cycle L+1.
  - mem_dout_b is valid in cycle L+2 and captured at the end of L+2.
  - m_valid first rises in cycle L+3.
- Throughput is one element per cycle on both streams when m_ready = 1. s_ready stays high across tile boundaries while a bank is free.
- Reset mid-operation:
  - Everything returns to the reset state immediately.
  - Any in-flight read data is discarded and tile contents are abandoned.

## Structure
- Package bram_xpose_pkg holds:
  - the bank_state_t enum (EMPTY, FILLING, FULL, DRAINING);
  - the functions wpr(), bank1_base() and the credit limit constant 3.
- One sub-module: xpose_out_fifo, a 3-entry synchronous FIFO with an occupancy output and async reset.
- The top level contains the writer, the reader, and the bank-state registers.

## Test plan
- Basic transpose (N=4, BRAM model attached): inputs 0..15, m_ready = 1.
  - Output is 0,4,8,12,1,5,9,13,...,15.
  - m_last is set only on 15.
  - First m_valid is 3 cycles after the last accept.
- Two back-to-back tiles (N=4, DATA_WIDTH=8):
  - s_ready stays 1 for all 32 inputs.
  - mem_addr_a runs 0..15, then 20..35.
  - Both transposed tiles are output in order.
- Both banks full (m_ready = 0):
  - s_ready drops after exactly 32 accepts.
  - The FIFO holds 3 entries and m_data = 0.
  - After m_ready rises, all 32 elements drain without loss.
- Random m_ready (50%) over 10 tiles: no dropped or duplicated element, and FIFO occupancy never exceeds 3.
- Reset mid-drain: assert rst at element 7 of tile 1.
  - All outputs return to reset values in the same cycle.
  - The next tile 100..115 transposes correctly.
- Collision monitor: in any cycle where mem_wen_a and mem_ren_b are both 1, floor(mem_addr_a/WPR) != floor(mem_addr_b/WPR).

Source files
------------

// File: rtl/bram_xpose_pkg.sv
// Shared types and sizing helpers for the ping-pong BRAM tile transpose controller.
package bram_xpose_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    // Output FIFO depth; also the cap on entries held plus reads in flight.
    localparam int unsigned CREDIT_LIMIT = 3;

    function automatic int unsigned wpr(input int unsigned phys_cols, input int unsigned data_width);
        return phys_cols / data_width;
    endfunction

    // Bank 1 starts on a physical-row boundary so the two banks never share a row.
    function automatic int unsigned bank1_base(input int unsigned tile_dim,
                                               input int unsigned phys_cols,
                                               input int unsigned data_width);
        int unsigned w;
        int unsigned elems;
        w     = wpr(phys_cols, data_width);
        elems = tile_dim * tile_dim;
        return ((elems + w - 1) / w) * w;
    endfunction

endpackage

// File: rtl/xpose_out_fifo.sv
// Small synchronous FIFO buffering BRAM read data ahead of the output stream.
module xpose_out_fifo
    import bram_xpose_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] mem_q [CREDIT_LIMIT];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [1:0]       occ_q;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(CREDIT_LIMIT - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CREDIT_LIMIT; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (occ_q == 2'd0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/bram_transpose_ctrl.sv
// Ping-pong NxN tile transposer: row-major writes on BRAM port A, column-major reads on port B.
module bram_transpose_ctrl
    import bram_xpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned TILE_DIM   = 16,
    parameter int unsigned PHYS_COLS  = 160
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_last,
    output logic [$clog2(DEPTH)-1:0]   mem_addr_a,
    output logic [$clog2(DEPTH)-1:0]   mem_addr_b,
    output logic [DATA_WIDTH-1:0]      mem_din_a,
    output logic [DATA_WIDTH-1:0]      mem_din_b,
    output logic                       mem_wen_a,
    output logic                       mem_ren_a,
    output logic                       mem_wen_b,
    output logic                       mem_ren_b,
    input  logic [DATA_WIDTH-1:0]      mem_dout_b
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned CW         = $clog2(TILE_DIM);
    localparam int unsigned TILE_ELEMS = TILE_DIM * TILE_DIM;
    localparam int unsigned WCW        = 2 * CW;
    localparam int unsigned BASE1      = bank1_base(TILE_DIM, PHYS_COLS, DATA_WIDTH);

    if (BASE1 + TILE_ELEMS > DEPTH) begin : g_bad_depth
        $error("bram_transpose_ctrl: both tile banks do not fit in DEPTH");
    end
    if (TILE_DIM < 2 || (TILE_DIM & (TILE_DIM - 1)) != 0) begin : g_bad_dim
        $error("bram_transpose_ctrl: TILE_DIM must be a power of two >= 2");
    end

    bank_state_t     bank_q [2];
    bank_state_t     bank_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [WCW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;
    logic            pend_q;
    logic            pend_last_q;

    logic            wr_fire;
    logic            rd_fire;
    logic            rd_last;
    logic            credit_ok;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [1:0]      fifo_occ;

    function automatic logic [AW-1:0] base_of(input logic bank);
        return bank ? AW'(BASE1) : '0;
    endfunction

    assign s_ready   = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
    assign wr_fire   = s_valid & s_ready;
    assign credit_ok = ({1'b0, fifo_occ} + {2'b00, pend_q}) < 3'(CREDIT_LIMIT);
    // A FULL bank may issue its first read in the same cycle it becomes DRAINING.
    assign rd_fire   = ((bank_q[rd_bank_q] == FULL) || (bank_q[rd_bank_q] == DRAINING)) & credit_ok;
    assign rd_last   = (r_q == CW'(TILE_DIM - 1)) && (c_q == CW'(TILE_DIM - 1));

    assign mem_wen_a  = wr_fire & ~rst;
    assign mem_din_a  = mem_wen_a ? s_data : '0;
    assign mem_addr_a = base_of(wr_bank_q) + AW'(wr_cnt_q);
    assign mem_ren_b  = rd_fire;
    // r*N + c is a plain concatenation because N is a power of two.
    assign mem_addr_b = base_of(rd_bank_q) + AW'({r_q, c_q});
    assign mem_din_b  = '0;
    assign mem_ren_a  = 1'b0;
    assign mem_wen_b  = 1'b0;

    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        r_d       = r_q;
        c_d       = c_q;
        if (wr_fire) begin
            if (wr_cnt_q == WCW'(TILE_ELEMS - 1)) begin
                bank_d[wr_bank_q] = FULL;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = FILLING;
                wr_cnt_d          = wr_cnt_q + 1'b1;
            end
        end
        if (rd_fire) begin
            if (rd_last) begin
                bank_d[rd_bank_q] = EMPTY;
                r_d               = '0;
                c_d               = '0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                bank_d[rd_bank_q] = DRAINING;
                if (r_q == CW'(TILE_DIM - 1)) begin
                    r_d = '0;
                    c_d = c_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            r_q         <= '0;
            c_q         <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            pend_q      <= rd_fire;
            pend_last_q <= rd_fire & rd_last;
        end
    end

    assign fifo_pop = m_valid & m_ready;
    assign m_valid  = ~fifo_empty;

    xpose_out_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pend_q),
        .din_i   ({mem_dout_b, pend_last_q}),
        .pop_i   (fifo_pop),
        .dout_o  ({m_data, m_last}),
        .empty_o (fifo_empty),
        .occ_o   (fifo_occ)
    );

endmodule

// File: tb/tb_bram_transpose_ctrl.sv
// Scoreboard bench for bram_transpose_ctrl with an attached dual-port BRAM model (N=4).
module tb_bram_transpose_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned N     = 4;
    localparam int unsigned PC    = 160;
    localparam int unsigned AW    = 11;
    localparam int unsigned WPR   = PC / DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_din_a, mem_din_b;
    logic          mem_wen_a, mem_ren_a, mem_wen_b, mem_ren_b;
    logic [DW-1:0] mem_dout_b = '0;
    logic [DW-1:0] bram [DEPTH];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned pops = 0;
    int unsigned cyc = 0;
    int unsigned last_acc_cyc = 0;
    int          occ_m = 0;
    bit          ren_d1 = 0, ren_d2 = 0, pop_d1 = 0;

    bram_transpose_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TILE_DIM   (N),
        .PHYS_COLS  (PC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .mem_addr_a (mem_addr_a),
        .mem_addr_b (mem_addr_b),
        .mem_din_a  (mem_din_a),
        .mem_din_b  (mem_din_b),
        .mem_wen_a  (mem_wen_a),
        .mem_ren_a  (mem_ren_a),
        .mem_wen_b  (mem_wen_b),
        .mem_ren_b  (mem_ren_b),
        .mem_dout_b (mem_dout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen_a) bram[mem_addr_a] <= mem_din_a;
        if (mem_ren_b) mem_dout_b <= bram[mem_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output scoreboard, independent FIFO occupancy model and port collision monitor.
    always @(negedge clk) begin
        if (rst) begin
            occ_m  = 0;
            ren_d1 = 0;
            ren_d2 = 0;
            pop_d1 = 0;
        end else begin
            occ_m = occ_m + int'(ren_d2) - int'(pop_d1);
            check("occ_model", 32'(u_dut.fifo_occ), 32'(occ_m));
            check("occ_le_3", 32'(occ_m <= 3), 1);
            ren_d2 = ren_d1;
            ren_d1 = mem_ren_b;
            pop_d1 = m_valid && m_ready;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("m_data", 32'(m_data), 32'(mon_e.d));
                    check("m_last", 32'(m_last), 32'(mon_e.l));
                end
                pops++;
            end
            if (mem_wen_a && mem_ren_b)
                check("collision", 32'((mem_addr_a / WPR) != (mem_addr_b / WPR)), 1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 1);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_m_last"}, 32'(m_last), 0);
        check({tag, "_wen_a"}, 32'(mem_wen_a), 0);
        check({tag, "_ren_b"}, 32'(mem_ren_b), 0);
        check({tag, "_addr_a"}, 32'(mem_addr_a), 0);
        check({tag, "_addr_b"}, 32'(mem_addr_b), 0);
        check({tag, "_din_a"}, 32'(mem_din_a), 0);
        check({tag, "_ties"}, 32'({mem_din_b, mem_ren_a, mem_wen_b}), 0);
        check({tag, "_occ"}, 32'(u_dut.fifo_occ), 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        sb.delete();
        pops = 0;
        rst  = 1'b0;
    endtask

    task automatic push_tile(input logic [DW-1:0] b);
        exp_t e;
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
                e.d = b + DW'(r * N + c);
                e.l = (r == N - 1) && (c == N - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_elem(input logic [DW-1:0] d, input int unsigned budget,
                              output bit acc, output logic [AW-1:0] addr,
                              output bit wen, output int unsigned stalls);
        acc    = 0;
        addr   = '0;
        wen    = 0;
        stalls = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (stalls < budget) begin
            @(negedge clk);
            if (s_ready) begin
                acc          = 1;
                addr         = mem_addr_a;
                wen          = mem_wen_a;
                last_acc_cyc = cyc;
                break;
            end
            stalls++;
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tile(input logic [DW-1:0] b, input bit chk_addr, input int unsigned abase,
                             input int unsigned budget);
        bit            acc, wen;
        logic [AW-1:0] addr;
        int unsigned   stalls;
        push_tile(b);
        for (int unsigned i = 0; i < N * N; i++) begin
            drive_elem(b + DW'(i), budget, acc, addr, wen, stalls);
            check("accept", 32'(acc), 1);
            check("wen_a", 32'(wen), 1);
            if (chk_addr) begin
                check("addr_a", 32'(addr), abase + i);
                check("no_stall", stalls, 0);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while ((sb.size() != 0 || m_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(sb.size() == 0 && !m_valid), 1);
    endtask

    initial begin
        bit            acc, wen, done;
        logic [AW-1:0] addr;
        int unsigned   stalls, acc_n, lat, n;

        do_reset();

        // Single tile: order, last flag, first-output latency.
        send_tile(8'd0, 1'b1, 0, 50);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) begin
                lat = cyc - last_acc_cyc;
                break;
            end
        end
        check("latency", lat, 3);
        wait_drain(100);

        // Back-to-back tiles at full rate into both banks.
        do_reset();
        send_tile(8'd0, 1'b1, 0, 50);
        send_tile(8'd16, 1'b1, 20, 50);
        wait_drain(100);

        // Both banks full with a stalled consumer.
        do_reset();
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        push_tile(8'd0);
        push_tile(8'd16);
        acc_n = 0;
        for (int i = 0; i < 40; i++) begin
            drive_elem(DW'(i), 30, acc, addr, wen, stalls);
            if (!acc) break;
            acc_n++;
        end
        s_valid = 1'b0;
        check("accepts_to_full", acc_n, 32);
        @(posedge clk);
        #1;
        check("full_occ", 32'(u_dut.fifo_occ), 3);
        check("full_m_valid", 32'(m_valid), 1);
        check("full_m_data", 32'(m_data), 0);
        check("full_s_ready", 32'(s_ready), 0);
        m_ready = 1'b1;
        wait_drain(200);

        // Ten tiles under random backpressure.
        do_reset();
        done = 0;
        fork
            begin
                for (int t = 0; t < 10; t++) send_tile(DW'(t * 16), 1'b0, 0, 500);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        wait_drain(300);

        // Reset in the middle of draining the second tile, then recover.
        do_reset();
        send_tile(8'd40, 1'b0, 0, 50);
        send_tile(8'd56, 1'b0, 0, 50);
        n = 0;
        while (pops < 23 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reached_elem7", 32'(pops >= 23), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        sb.delete();
        @(posedge clk);
        #1;
        pops = 0;
        rst  = 1'b0;
        send_tile(8'd100, 1'b1, 0, 50);
        wait_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
